// File: rtl/mp_param.sv
// mp_param: parametrised mini processor. A host loads the register file, the
// instruction memory and the program length over a simple slave bus, then sets
// start; the block runs the program and raises a level interrupt when it ends.
// Optional feature macro: MP_MUL_EN. Define it to build the iterative radix-2
// shift-add multiplier (opcode 6, MUL_WAIT state). Leave it undefined and
// opcode 6 executes as a NOP.
module mp_param #(
  parameter int DW       = 32,
  parameter int RF_DEPTH = 16,
  parameter int NINST    = 10
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            s0_sel,
  input  logic            s_wr,
  input  logic [15:0]     s_addr,
  input  logic [DW-1:0]   s_din,
  output logic [2*DW-1:0] s_dout,
  output logic            interrupt_out
);

  localparam int RW = 2 * DW;
  localparam int CW = $clog2(DW + 1);
`ifdef MP_MUL_EN
  localparam bit MUL_BUILT = 1'b1;
`else
  localparam bit MUL_BUILT = 1'b0;
`endif

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_MUL  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_READ_A = 3'd2,
    S_READ_B = 3'd3,
    S_EXEC   = 3'd4,
    S_WRITE  = 3'd5,
    S_DONE   = 3'd6
`ifdef MP_MUL_EN
    , S_MUL_WAIT = 3'd7
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      pc_q, pc_d;
  logic [4:0]      len_q, len_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            irq_arm_q, irq_arm_d;
  logic            int_q, int_d;
  logic [15:0]     instr_q, instr_d;
  logic [DW-1:0]   opa_q, opa_d;
  logic [DW-1:0]   opb_q, opb_d;
  logic [RW-1:0]   result_q, result_d;
  logic [RW-1:0]   rf_q [RF_DEPTH];
  logic [RW-1:0]   rf_d [RF_DEPTH];
  logic [15:0]     imem_q [NINST];
  logic [15:0]     imem_d [NINST];
`ifdef MP_MUL_EN
  logic [RW-1:0]   mcand_q, mcand_d;
  logic [DW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   mcnt_q, mcnt_d;
`endif

  logic            host_wr;
  logic [3:0]      region;
  logic [3:0]      idx;
  logic            start_req;
  logic [4:0]      pc_inc;
  logic [3:0]      op_q;
  logic            op_writes;
  logic [DW:0]     sum_w;
  logic [DW:0]     diff_w;
  logic [15:0]     fetch_word;
  logic [DW-1:0]   rf_a;
  logic [DW-1:0]   rf_b;
  logic            unused_addr;

  // Address bits above the region field carry no meaning for this block.
  assign unused_addr = ^s_addr[15:8];

  assign host_wr   = s0_sel & s_wr;
  assign region    = s_addr[7:4];
  assign idx       = s_addr[3:0];
  assign start_req = host_wr && (region == 4'h2) && (idx == 4'h0) && s_din[0] && !busy_q;
  assign pc_inc    = pc_q + 5'd1;
  assign op_q      = instr_q[15:12];
  assign op_writes = ((op_q >= OP_ADD) && (op_q <= OP_XOR)) || (MUL_BUILT && (op_q == OP_MUL));
  assign sum_w     = {1'b0, opa_q} + {1'b0, opb_q};
  assign diff_w    = {1'b0, opa_q} - {1'b0, opb_q};
  assign interrupt_out = int_q;

  // Array read ports: instruction at pc and the low halves of RF[Ra] / RF[Rb].
  always_comb begin
    fetch_word = '0;
    rf_a       = '0;
    rf_b       = '0;
    for (int i = 0; i < NINST; i++) begin
      if (pc_q == 5'(i)) fetch_word = imem_q[i];
    end
    for (int i = 0; i < RF_DEPTH; i++) begin
      if (instr_q[7:4] == 4'(i)) rf_a = rf_q[i][DW-1:0];
      if (instr_q[3:0] == 4'(i)) rf_b = rf_q[i][DW-1:0];
    end
  end

  // Host read mux: combinational, zero for unmapped or out-of-range locations.
  always_comb begin
    s_dout = '0;
    if (s0_sel && !s_wr) begin
      case (region)
        4'h0: begin
          for (int i = 0; i < RF_DEPTH; i++) begin
            if (idx == 4'(i)) s_dout = rf_q[i];
          end
        end
        4'h1: begin
          for (int i = 0; i < NINST; i++) begin
            if (idx == 4'(i)) s_dout = RW'(imem_q[i]);
          end
        end
        4'h2: begin
          if (idx == 4'h1) s_dout = RW'({pc_q[3:0], len_q[3:0], 6'b0, done_q, busy_q});
        end
        default: s_dout = '0;
      endcase
    end
  end

  // Next-state: host writes, interrupt handshake and the sequencer FSM.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    busy_d    = busy_q;
    done_d    = done_q;
    irq_arm_d = 1'b0;
    int_d     = int_q;
    instr_d   = instr_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    result_d  = result_q;
    rf_d      = rf_q;
    imem_d    = imem_q;
`ifdef MP_MUL_EN
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    mcnt_d    = mcnt_q;
`endif

    // The interrupt line rises one cycle after DONE.
    if (irq_arm_q) int_d = 1'b1;

    // Host writes are only honoured while no program is running.
    if (host_wr && !busy_q) begin
      case (region)
        4'h0: begin
          for (int i = 0; i < RF_DEPTH; i++) begin
            if (idx == 4'(i)) rf_d[i] = RW'(s_din);
          end
        end
        4'h1: begin
          for (int i = 0; i < NINST; i++) begin
            if (idx == 4'(i)) imem_d[i] = 16'(s_din);
          end
        end
        4'h2: begin
          if (idx == 4'h1) len_d = (s_din > DW'(NINST)) ? 5'(NINST) : 5'(s_din);
          if (idx == 4'h2) begin
            int_d     = 1'b0;
            irq_arm_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (start_req) begin
          pc_d      = '0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          int_d     = 1'b0;
          irq_arm_d = 1'b0;
          state_d   = (len_q == 5'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        instr_d = fetch_word;
        state_d = (fetch_word[15:12] == OP_HALT) ? S_DONE : S_READ_A;
      end
      S_READ_A: begin
        opa_d   = rf_a;
        state_d = S_READ_B;
      end
      S_READ_B: begin
        opb_d   = rf_b;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WRITE;
        case (op_q)
          OP_ADD:  result_d = RW'(sum_w);
          OP_SUB:  result_d = {{DW{diff_w[DW]}}, diff_w[DW-1:0]};
          OP_AND:  result_d = RW'(opa_q & opb_q);
          OP_OR:   result_d = RW'(opa_q | opb_q);
          OP_XOR:  result_d = RW'(opa_q ^ opb_q);
          default: result_d = result_q;
        endcase
`ifdef MP_MUL_EN
        if (op_q == OP_MUL) begin
          result_d = '0;
          mcand_d  = RW'(opa_q);
          mplier_d = opb_q;
          mcnt_d   = '0;
          state_d  = S_MUL_WAIT;
        end
`endif
      end
`ifdef MP_MUL_EN
      S_MUL_WAIT: begin
        // One multiplier bit per cycle: add the shifted multiplicand when set.
        if (mplier_q[0]) result_d = result_q + mcand_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        mcnt_d   = mcnt_q + CW'(1);
        if (mcnt_q == CW'(DW - 1)) state_d = S_WRITE;
      end
`endif
      S_WRITE: begin
        if (op_writes) begin
          for (int i = 0; i < RF_DEPTH; i++) begin
            if (instr_q[11:8] == 4'(i)) rf_d[i] = result_q;
          end
        end
        pc_d    = pc_inc;
        state_d = (pc_inc == len_q) ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        busy_d    = 1'b0;
        done_d    = 1'b1;
        irq_arm_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset clears everything including both memories.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      len_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      irq_arm_q <= 1'b0;
      int_q     <= 1'b0;
      instr_q   <= '0;
      opa_q     <= '0;
      opb_q     <= '0;
      result_q  <= '0;
      for (int i = 0; i < RF_DEPTH; i++) rf_q[i] <= '0;
      for (int i = 0; i < NINST; i++) imem_q[i] <= '0;
`ifdef MP_MUL_EN
      mcand_q   <= '0;
      mplier_q  <= '0;
      mcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      len_q     <= len_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      irq_arm_q <= irq_arm_d;
      int_q     <= int_d;
      instr_q   <= instr_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      result_q  <= result_d;
      rf_q      <= rf_d;
      imem_q    <= imem_d;
`ifdef MP_MUL_EN
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      mcnt_q    <= mcnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mp_param.sv
// tb_mp_param: directed and randomized programs for mp_param, checked against
// a sequential instruction-level model (register values and cycle counts).
module tb_mp_param;

  localparam int DW    = 32;
  localparam int NINST = 10;

  logic          clk;
  logic          reset_n;
  logic          s0_sel;
  logic          s_wr;
  logic [15:0]   s_addr;
  logic [DW-1:0] s_din;
  logic [63:0]   s_dout;
  logic          interrupt_out;

  int tests;
  int fails;

  longint unsigned rf_m [16];
  logic [15:0]     prog_m [16];
  int              len_m;

  mp_param #(.DW(DW), .RF_DEPTH(16), .NINST(NINST)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s0_sel(s0_sel),
    .s_wr(s_wr),
    .s_addr(s_addr),
    .s_din(s_din),
    .s_dout(s_dout),
    .interrupt_out(interrupt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    s0_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
    @(negedge clk);
    s0_sel = 1'b0; s_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [63:0] d);
    @(negedge clk);
    s0_sel = 1'b1; s_wr = 1'b0; s_addr = a;
    #1 d = s_dout;
    s0_sel = 1'b0;
  endtask

  task automatic write_rf(input int r, input logic [31:0] v);
    bus_write(16'(r), v);
    rf_m[r] = longint'(v);
  endtask

  task automatic load_prog(input int len);
    for (int i = 0; i < len; i++) bus_write(16'h0010 + 16'(i), 32'(prog_m[i]));
    bus_write(16'h0021, 32'(len));
    len_m = len;
  endtask

  // Cycle count from start edge (c0 cycles already elapsed) to interrupt high.
  task automatic wait_irq(input int c0, input int budget, output int cyc);
    cyc = c0;
    while (interrupt_out !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Instruction-level model: executes the program, updating rf_m, and
  // returns the expected start-to-interrupt latency and final pc.
  task automatic model_run(output int exp_cyc, output int exp_pc);
    int pc;
    longint unsigned a, b;
    logic [15:0] w;
    logic [3:0] op, rd, ra, rb;
    pc = 0;
    exp_cyc = 2;
    while (pc < len_m) begin
      w = prog_m[pc];
      op = w[15:12]; rd = w[11:8]; ra = w[7:4]; rb = w[3:0];
      if (op == 4'hF) begin
        exp_cyc += 1;
        break;
      end
      a = rf_m[ra] & 64'hFFFF_FFFF;
      b = rf_m[rb] & 64'hFFFF_FFFF;
      exp_cyc += 5;
      case (op)
        4'h1: rf_m[rd] = a + b;
        4'h2: rf_m[rd] = (a >= b) ? (a - b) : (64'hFFFF_FFFF_0000_0000 | ((a - b) & 64'hFFFF_FFFF));
        4'h3: rf_m[rd] = a & b;
        4'h4: rf_m[rd] = a | b;
        4'h5: rf_m[rd] = a ^ b;
        4'h6: begin
`ifdef MP_MUL_EN
          rf_m[rd] = a * b;
          exp_cyc += DW;
`endif
        end
        default: ;
      endcase
      pc++;
    end
    exp_pc = pc;
  endtask

  // Start the loaded program, then compare latency, status and every RF entry.
  task automatic run_check(input string tag, output int cyc);
    int ec, ep;
    logic [63:0] rdata;
    logic [15:0] st;
    model_run(ec, ep);
    bus_write(16'h0020, 32'h1);
    wait_irq(0, ec + 50, cyc);
    check({tag, " cycles"}, 64'(cyc), 64'(ec));
    st = {4'(ep), 4'(len_m), 6'b0, 2'b10};
    bus_read(16'h0021, rdata);
    check({tag, " status"}, rdata, 64'(st));
    for (int r = 0; r < 16; r++) begin
      bus_read(16'(r), rdata);
      check($sformatf("%s rf%0d", tag, r), rdata, rf_m[r]);
    end
    $display("[TB] run %s: len %0d cycles %0d pc %0d", tag, len_m, cyc, ep);
  endtask

  initial begin
    int cyc;
    int ec, ep;
    logic [63:0] rdata;
    logic [31:0] v;
    int ops [9];

    tests = 0; fails = 0;
    reset_n = 1'b0; s0_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
    for (int i = 0; i < 16; i++) begin rf_m[i] = 0; prog_m[i] = '0; end
    len_m = 0;
    ops = '{0, 1, 2, 3, 4, 5, 6, 9, 15};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state.
    bus_read(16'h0021, rdata);  check("reset status", rdata, 64'h0);
    check("reset irq", 64'(interrupt_out), 64'h0);
    bus_read(16'h0003, rdata);  check("reset rf3", rdata, 64'h0);
    bus_read(16'h0010, rdata);  check("reset imem0", rdata, 64'h0);

    // ADD: RF3 = 5 + 7 with interrupt 7 cycles after start.
    write_rf(1, 32'd5); write_rf(2, 32'd7);
    prog_m[0] = 16'h1312; load_prog(1);
    run_check("add", cyc);
    check("add latency", 64'(cyc), 64'd7);
    bus_read(16'h0003, rdata);  check("add rf3", rdata, 64'd12);

    // SUB with borrow extension, then interrupt clear.
    write_rf(1, 32'd3); write_rf(2, 32'd5);
    prog_m[0] = 16'h2412; load_prog(1);
    run_check("sub", cyc);
    bus_read(16'h0004, rdata);  check("sub rf4", rdata, 64'hFFFF_FFFF_FFFF_FFFE);
    check("irq held", 64'(interrupt_out), 64'h1);
    bus_write(16'h0022, 32'h0);
    check("irq cleared", 64'(interrupt_out), 64'h0);

    // MUL.
    write_rf(1, 32'hFFFF_FFFF); write_rf(2, 32'd2);
    prog_m[0] = 16'h6512; load_prog(1);
    run_check("mul", cyc);
    bus_read(16'h0005, rdata);
`ifdef MP_MUL_EN
    check("mul rf5", rdata, 64'h1_FFFF_FFFE);
    check("mul latency", 64'(cyc), 64'd39);
`else
    check("mul rf5 nop", rdata, 64'h0);
    check("mul latency", 64'(cyc), 64'd7);
`endif

    // HALT mid-program; start and RF write while busy are ignored.
    write_rf(1, 32'd5); write_rf(2, 32'd7); write_rf(3, 32'd0); write_rf(6, 32'd0);
    prog_m[0] = 16'h1312; prog_m[1] = 16'hF000; prog_m[2] = 16'h1612; load_prog(3);
    model_run(ec, ep);
    bus_write(16'h0020, 32'h1);
    bus_write(16'h0020, 32'h1);
    bus_write(16'h0001, 32'd99);
    wait_irq(4, 200, cyc);
    check("halt cycles", 64'(cyc), 64'd8);
    bus_read(16'h0021, rdata);  check("halt status", rdata, 64'h1302);
    bus_read(16'h0001, rdata);  check("busy rf write", rdata, 64'd5);
    bus_read(16'h0003, rdata);  check("halt rf3", rdata, 64'd12);
    bus_read(16'h0006, rdata);  check("halt rf6", rdata, 64'd0);
    $display("[TB] run halt: cycles %0d", cyc);

    // Zero-length program goes straight to DONE.
    load_prog(0);
    run_check("len0", cyc);
    check("len0 latency", 64'(cyc), 64'd2);

    // Length clamp and out-of-range IMEM / unmapped region.
    bus_write(16'h0021, 32'd20);
    bus_read(16'h0021, rdata);  check("len clamp", 64'(rdata[11:8]), 64'hA);
    bus_write(16'h001C, 32'hABCD);
    bus_read(16'h001C, rdata);  check("imem oob", rdata, 64'h0);
    bus_read(16'h0031, rdata);  check("region3", rdata, 64'h0);

    // Reset in the middle of a program.
    write_rf(1, 32'hFFFF_FFFF); write_rf(2, 32'd2);
    prog_m[0] = 16'h6512; load_prog(1);
    bus_write(16'h0020, 32'h1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    s0_sel = 1'b1; s_wr = 1'b0; s_addr = 16'h0021;
    #1 check("midrst status", s_dout, 64'h0);
    check("midrst irq", 64'(interrupt_out), 64'h0);
    s_addr = 16'h0001;
    #1 check("midrst rf1", s_dout, 64'h0);
    s0_sel = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin rf_m[i] = 0; prog_m[i] = '0; end
    len_m = 0;
    write_rf(1, 32'd5); write_rf(2, 32'd7);
    prog_m[0] = 16'h1312; load_prog(1);
    run_check("postrst", cyc);
    bus_read(16'h0003, rdata);  check("postrst rf3", rdata, 64'd12);

    // Randomized programs.
    for (int it = 0; it < 12; it++) begin
      for (int r = 0; r < 16; r++) begin
        case ($urandom_range(0, 5))
          0: v = 32'h0;
          1: v = 32'hFFFF_FFFF;
          default: v = $urandom;
        endcase
        write_rf(r, v);
      end
      ec = $urandom_range(1, NINST);
      for (int i = 0; i < ec; i++) begin
        prog_m[i] = {4'(ops[$urandom_range(0, 8)]), 12'($urandom)};
      end
      load_prog(ec);
      run_check($sformatf("rand%0d", it), cyc);
      bus_write(16'h0022, 32'h0);
      check($sformatf("rand%0d clr", it), 64'(interrupt_out), 64'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
